gauss_window_streamer: RTL and testbench

- Streaming producer that feeds the 11-tap Gaussian dot-product stage.
- Accepts one image row as a pixel stream (valid/ready, last-flag).
- Emits exactly one 11-pixel window per input pixel, centred on that pixel.
- Replicates edge pixels at both row ends, so the convolution output row is the same length as the input row.

---
 rtl/gauss_pkg.sv | 22 ++
 rtl/gauss_window_shreg.sv | 31 +++
 rtl/gauss_window_streamer.sv | 155 +++++++++++++++
 tb/tb_gauss_window_streamer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared constants and types for the Gaussian window streamer.
//   PIX_W    : pixel width in bits
//   TAPS     : window length (odd)
//   HALF     : taps on each side of the centre
//   pixel_t  : one pixel
//   window_t : tap storage, index TAPS-1 holds the newest pixel
//   state_t  : streamer FSM states
package gauss_pkg;
   localparam int PIX_W = 8;
   localparam int TAPS  = 11;
   localparam int HALF  = (TAPS - 1) / 2;

   typedef logic [PIX_W-1:0] pixel_t;
   typedef pixel_t window_t [TAPS-1:0];

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN,
      FLUSH
   } state_t;
endpackage

// File: rtl/gauss_window_shreg.sv
// Tap storage for the window streamer. It holds no control logic.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears every tap)
//   fill       : load every tap with din (first pixel of a row)
//   shift      : window[i] <= window[i+1], window[TAPS-1] <= din
//   din        : incoming pixel
//   window     : current taps, window[TAPS-1] is the newest
module gauss_window_shreg #(
   parameter int PIX_W = gauss_pkg::PIX_W,
   parameter int TAPS  = gauss_pkg::TAPS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fill,
   input  logic             shift,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] window [TAPS-1:0]
);
   import gauss_pkg::*;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) window[i] <= '0;
      end else if (fill) begin
         for (int i = 0; i < TAPS; i++) window[i] <= din;
      end else if (shift) begin
         for (int i = 0; i < TAPS - 1; i++) window[i] <= window[i+1];
         window[TAPS-1] <= din;
      end
   end
endmodule

// File: rtl/gauss_window_streamer.sv
// Streams one TAPS-pixel window per input pixel, centred on that pixel, with
// the edge pixels replicated at both row ends so the filtered row keeps its
// length.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : input pixel handshake, s_data pixel, s_last ends row
//   m_valid/m_ready   : output window handshake
//   m_window          : tap i at [i*PIX_W +: PIX_W], tap HALF is the centre
//   m_last            : last window of the row
//   busy              : a row is in progress
//
// state | meaning
// IDLE  | waiting for first pixel of a row; it is replicated into all taps
// PRIME | collecting pixels 1..HALF; the emit of window 0 ends priming
// RUN   | every accepted pixel shifts in and emits a window
// FLUSH | HALF shifts of the last pixel to finish the row, input blocked
module gauss_window_streamer #(
   parameter int PIX_W = gauss_pkg::PIX_W,
   parameter int TAPS  = gauss_pkg::TAPS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [PIX_W-1:0]      s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [TAPS*PIX_W-1:0] m_window,
   output logic                  m_last,
   output logic                  busy
);
   import gauss_pkg::*;

   localparam int HALF  = (TAPS - 1) / 2;
   localparam int CNT_W = $clog2(HALF + 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

   state_t state, state_nxt;
   logic [CNT_W-1:0] shift_cnt, shift_cnt_nxt;
   logic [CNT_W-1:0] flush_cnt, flush_cnt_nxt;
   logic [CNT_W-1:0] cnt_sat;
   logic gate, accept, fill, shift, emit, emit_last;
   logic [PIX_W-1:0] din;
   logic [PIX_W-1:0] win [TAPS-1:0];
   logic [TAPS*PIX_W-1:0] win_shifted;

   gauss_window_shreg #(
      .PIX_W (PIX_W),
      .TAPS  (TAPS)
   ) u_shreg (
      .clk    (clk),
      .rst_n  (rst_n),
      .fill   (fill),
      .shift  (shift),
      .din    (din),
      .window (win)
   );

   // The output slot can take a new window when empty or draining this cycle.
   assign gate    = !m_valid || m_ready;
   assign s_ready = (state != FLUSH) && gate;
   assign accept  = s_valid && s_ready;
   assign busy    = (state != IDLE);
   assign cnt_sat = (shift_cnt == CNT_HALF) ? shift_cnt : shift_cnt + CNT_W'(1);

   // Window as it will look after this cycle's shift; emits load this view so
   // the window leaves on the same edge that completes it.
   always_comb begin
      win_shifted = '0;
      for (int i = 0; i < TAPS - 1; i++) win_shifted[i*PIX_W +: PIX_W] = win[i+1];
      win_shifted[(TAPS-1)*PIX_W +: PIX_W] = din;
   end

   always_comb begin
      state_nxt     = state;
      shift_cnt_nxt = shift_cnt;
      flush_cnt_nxt = flush_cnt;
      fill          = 1'b0;
      shift         = 1'b0;
      din           = s_data;
      emit          = 1'b0;
      emit_last     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               fill          = 1'b1;
               shift_cnt_nxt = '0;
               state_nxt     = s_last ? FLUSH : PRIME;
            end
         end
         PRIME: begin
            if (accept) begin
               shift         = 1'b1;
               shift_cnt_nxt = cnt_sat;
               emit          = (cnt_sat == CNT_HALF);
               if (s_last)    state_nxt = FLUSH;
               else if (emit) state_nxt = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               shift = 1'b1;
               emit  = 1'b1;
               if (s_last) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (gate) begin
               // Short rows reach HALF only during flush, which delays their
               // first window until enough right-edge copies are in place.
               shift         = 1'b1;
               din           = win[TAPS-1];
               shift_cnt_nxt = cnt_sat;
               emit          = (cnt_sat == CNT_HALF);
               flush_cnt_nxt = flush_cnt + CNT_W'(1);
               if (flush_cnt_nxt == CNT_HALF) begin
                  emit_last     = emit;
                  state_nxt     = IDLE;
                  shift_cnt_nxt = '0;
                  flush_cnt_nxt = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         shift_cnt <= shift_cnt_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
         m_window <= '0;
      end else if (emit) begin
         m_valid  <= 1'b1;
         m_last   <= emit_last;
         m_window <= win_shifted;
      end else if (m_ready) begin
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_gauss_window_streamer.sv
// Directed and throttled-stream bench for gauss_window_streamer. Expected
// windows come from a clamp-index model of the row plus hand-computed
// constants for the key windows.
module tb_gauss_window_streamer;
   localparam int PIX_W = 8;
   localparam int TAPS  = 11;
   localparam int HALF  = 5;
   localparam int WW    = TAPS * PIX_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic s_valid = 1'b0;
   logic s_ready;
   logic [PIX_W-1:0] s_data = '0;
   logic s_last = 1'b0;
   logic m_valid;
   logic m_ready = 1'b1;
   logic [WW-1:0] m_window;
   logic m_last;
   logic busy;

   typedef struct {
      logic [WW-1:0] win;
      logic          last;
   } rec_t;

   rec_t cap_q[$];
   rec_t exp_q[$];
   rec_t cap_r;
   int   rdy_mode = 0;
   int   n_vec = 0;
   int   n_err = 0;

   gauss_window_streamer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_window (m_window),
      .m_last   (m_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // A window seen valid+ready at the negedge transfers on the next posedge.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         cap_r.win  = m_window;
         cap_r.last = m_last;
         cap_q.push_back(cap_r);
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] want);
      n_vec++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   function automatic logic [WW-1:0] ref_win(input logic [7:0] px[$], input int x);
      logic [WW-1:0] r;
      int idx;
      r = '0;
      for (int i = 0; i < TAPS; i++) begin
         idx = x - HALF + i;
         if (idx < 0) idx = 0;
         if (idx > px.size() - 1) idx = px.size() - 1;
         r[i*PIX_W +: PIX_W] = px[idx];
      end
      return r;
   endfunction

   function automatic rec_t cap_at(input int k);
      rec_t r;
      r.win  = '0;
      r.last = 1'b0;
      if (k < cap_q.size()) r = cap_q[k];
      return r;
   endfunction

   task automatic send_pix(input logic [7:0] d, input logic last, input int gap);
      int t;
      bit done;
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      t = 0;
      done = 1'b0;
      while (!done && t < 1000) begin
         @(negedge clk);
         done = s_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!done) chk("send timeout", 0, 1);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_row(input logic [7:0] px[$], input int max_gap);
      rec_t e;
      for (int x = 0; x < px.size(); x++) begin
         e.win  = ref_win(px, x);
         e.last = (x == px.size() - 1);
         exp_q.push_back(e);
      end
      for (int x = 0; x < px.size(); x++)
         send_pix(px[x], x == px.size() - 1, (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (cap_q.size() < exp_q.size() && t < 3000) begin
         @(posedge clk);
         t++;
      end
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic compare_all(input string tag);
      int n;
      chk({tag, " count"}, cap_q.size(), exp_q.size());
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s win%0d", tag, i), cap_q[i].win, exp_q[i].win);
         chk($sformatf("%s last%0d", tag, i), cap_q[i].last, exp_q[i].last);
      end
   endtask

   task automatic clear_q();
      cap_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] px[$];
      logic [7:0] px2[$];
      logic [WW-1:0] w0;
      int t;

      // reset state
      #12;
      chk("rst m_valid", m_valid, 0);
      chk("rst m_last", m_last, 0);
      chk("rst m_window", m_window, 0);
      chk("rst busy", busy, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst s_ready", s_ready, 1);

      // N=12 row, 10..120, no backpressure
      px.delete();
      for (int i = 1; i <= 12; i++) px.push_back(8'(i * 10));
      clear_q();
      send_row(px, 0);
      wait_drain();
      chk("n12 w0", cap_at(0).win, 88'h3c32281e140a0a0a0a0a0a);
      chk("n12 w11", cap_at(11).win, 88'h7878787878786e645a5046);
      chk("n12 last10", cap_at(10).last, 0);
      chk("n12 last11", cap_at(11).last, 1);
      compare_all("n12");

      // N=1: latency, flush blocking, single window
      clear_q();
      px2.delete();
      px2.push_back(8'h55);
      send_row(px2, 0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("n1 s_ready flush%0d", k), s_ready, 0);
         chk($sformatf("n1 m_valid early%0d", k), m_valid, 0);
         @(posedge clk);
      end
      @(negedge clk);
      chk("n1 m_valid", m_valid, 1);
      chk("n1 m_last", m_last, 1);
      chk("n1 window", m_window, {11{8'h55}});
      chk("n1 s_ready after", s_ready, 1);
      @(posedge clk); #1;
      wait_drain();
      compare_all("n1");

      // N=12 with a 4-cycle stall after window 3
      clear_q();
      fork
         send_row(px, 0);
         begin
            t = 0;
            while (cap_q.size() < 4 && t < 500) begin
               @(posedge clk);
               t++;
            end
            #1;
            m_ready = 1'b0;
            w0 = m_window;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk($sformatf("stall s_ready%0d", k), s_ready, 0);
               chk($sformatf("stall m_valid%0d", k), m_valid, 1);
               chk($sformatf("stall window%0d", k), m_window, w0);
               @(posedge clk);
               #1;
            end
            m_ready = 1'b1;
         end
      join
      wait_drain();
      compare_all("stall");

      // back-to-back rows {1,2,3} and {100..106}
      clear_q();
      px2.delete();
      for (int i = 1; i <= 3; i++) px2.push_back(8'(i));
      send_row(px2, 0);
      px2.delete();
      for (int i = 100; i <= 106; i++) px2.push_back(8'(i));
      send_row(px2, 0);
      wait_drain();
      chk("b2b last3", cap_at(2).last, 1);
      chk("b2b last10", cap_at(9).last, 1);
      chk("b2b row2 w0", cap_at(3).win, 88'h6968676665646464646464);
      compare_all("b2b");

      // reset during FLUSH of an N=8 row, then an N=6 row
      clear_q();
      px2.delete();
      for (int i = 0; i < 8; i++) px2.push_back(8'(200 + i));
      send_row(px2, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rstmid m_valid", m_valid, 0);
      chk("rstmid busy", busy, 0);
      chk("rstmid m_last", m_last, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      clear_q();
      @(posedge clk); #1;
      px2.delete();
      for (int i = 1; i <= 6; i++) px2.push_back(8'(i));
      send_row(px2, 0);
      wait_drain();
      chk("rstmid w5", cap_at(5).win, 88'h0606060606060504030201);
      compare_all("rstmid");

      // throttled rows N=1..20 with random pixels
      clear_q();
      rdy_mode = 1;
      for (int n = 1; n <= 20; n++) begin
         px2.delete();
         for (int i = 0; i < n; i++) px2.push_back(8'($urandom_range(0, 255)));
         send_row(px2, 2);
      end
      wait_drain();
      rdy_mode = 0;
      m_ready = 1'b1;
      compare_all("rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
